ws2812_tx: RTL and testbench

- Serial LED transmitter downstream of the POV peripheral's pixel_color output.
- Accepts 24-bit RGB pixels over a valid/ready handshake and drives a WS2812-style one-wire line (GRB order, MSB first).
- Sends N_LEDS pixels per frame, then holds the line low for the latch gap and signals frame completion.
- Sits between the POV framebuffer read path and the physical LED strip pin.

---
 rtl/pov_led_pkg.sv | 22 ++
 rtl/ws2812_bit_cell.sv | 55 +++++
 rtl/ws2812_tx.sv | 160 ++++++++++++++++
 tb/tb_ws2812_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pov_led_pkg.sv
// Shared types, default 50 MHz timing and colour helpers for the POV LED output path.
package pov_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GAP   = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_N_LEDS    = 64;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_RESET_CYC = 14000;

    // The strip expects green first on the wire.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_cell.sv
// One WS2812 bit cell: line high for T1H/T0H cycles, then low until BIT_CYC cycles elapse.
// A start strobe during the final cycle chains the next cell with no dead cycle.
module ws2812_bit_cell
    import pov_led_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic line,
    output logic cell_last
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] CELL_TOP = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HI0_TOP  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] HI1_TOP  = CW'(T1H_CYC - 1);

    logic          active;
    logic [CW-1:0] cell_cnt;
    logic [CW-1:0] hi_cnt;

    assign cell_last = active && (cell_cnt == '0);

    // Both timers count down; the line register already holds the level for the coming cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            cell_cnt <= '0;
            hi_cnt   <= '0;
            line     <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            cell_cnt <= CELL_TOP;
            hi_cnt   <= bit_val ? HI1_TOP : HI0_TOP;
            line     <= 1'b1;
        end else if (active) begin
            if (cell_cnt == '0) begin
                active <= 1'b0;
                line   <= 1'b0;
            end else begin
                cell_cnt <= cell_cnt - CW'(1);
                line     <= (hi_cnt != '0);
                if (hi_cnt != '0) begin
                    hi_cnt <= hi_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 one-wire transmitter: pixel handshake, GRB shifting, frame sequencing and latch gap.
//   state | meaning
//   IDLE  | line low, ready for the first pixel of a frame
//   SEND  | 24 GRB bit cells going out, MSB first
//   GAP   | mid-frame, line low, waiting for the next pixel (times out to underrun)
//   LATCH | line low for RESET_CYC cycles so the strip latches the frame
module ws2812_tx
    import pov_led_pkg::*;
#(
    parameter int N_LEDS    = DEF_N_LEDS,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC,
    localparam int IDX_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      pixel_color,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic [IDX_W-1:0] led_idx,
    output logic             led_dout,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int CNT_MAX = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0]    WAIT_LAST = CW'(RESET_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_LEDS - 1);

    state_t        state_q;
    state_t        state_d;
    logic [22:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] wait_cnt;
    logic          frame_flag;
    logic [23:0]   pix_grb;
    logic          xfer;
    logic          cell_last;
    logic          cell_start;
    logic          cell_bit;
    logic          cell_next;
    logic          pix_end;
    logic          last_led;
    logic          wait_tc;
    logic          gap_done;
    logic          latch_done;

    assign pix_grb    = rgb_to_grb(pixel_color);
    assign xfer       = pixel_valid && pixel_ready;
    assign last_led   = (led_idx == IDX_LAST);
    assign wait_tc    = (wait_cnt == WAIT_LAST);
    assign pix_end    = (state_q == SEND) && cell_last && (bit_cnt == 5'd0);
    assign cell_next  = (state_q == SEND) && cell_last && (bit_cnt != 5'd0);
    assign gap_done   = (state_q == GAP) && !xfer && wait_tc;
    assign latch_done = (state_q == LATCH) && wait_tc;
    assign cell_start = xfer || cell_next;
    assign cell_bit   = xfer ? pix_grb[23] : shreg[22];
    assign busy       = (state_q != IDLE);

    ws2812_bit_cell #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_cell (
        .clk       (clk),
        .reset     (reset),
        .start     (cell_start),
        .bit_val   (cell_bit),
        .line      (led_dout),
        .cell_last (cell_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LATCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready in SEND only on the last cycle of the final cell, and never for the frame's last pixel.
    always_comb begin
        state_d     = state_q;
        pixel_ready = 1'b0;
        case (state_q)
            IDLE: begin
                pixel_ready = 1'b1;
                if (pixel_valid) state_d = SEND;
            end
            SEND: begin
                pixel_ready = pix_end && !last_led;
                if (pix_end) begin
                    if (last_led)         state_d = LATCH;
                    else if (pixel_valid) state_d = SEND;
                    else                  state_d = GAP;
                end
            end
            GAP: begin
                pixel_ready = 1'b1;
                if (pixel_valid)  state_d = SEND;
                else if (wait_tc) state_d = IDLE;
            end
            LATCH: begin
                if (wait_tc) state_d = IDLE;
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            led_idx    <= '0;
            wait_cnt   <= '0;
            frame_flag <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            if (xfer) begin
                shreg      <= pix_grb[22:0];
                bit_cnt    <= 5'd23;
                frame_flag <= 1'b1;
            end else if (cell_next) begin
                shreg   <= {shreg[21:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end

            if (pix_end && !last_led) begin
                led_idx <= led_idx + IDX_W'(1);
            end

            if (gap_done) begin
                led_idx    <= '0;
                underrun   <= 1'b1;
                frame_flag <= 1'b0;
            end

            if (latch_done) begin
                led_idx    <= '0;
                frame_done <= frame_flag;
                frame_flag <= 1'b0;
            end

            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (state_q == GAP || state_q == LATCH) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// Self-checking bench for ws2812_tx with short sim timing (BIT 6, T0H 2, T1H 4, gap 10, 2 LEDs).
module tb_ws2812_tx;

    localparam int N_LEDS    = 2;
    localparam int BIT_CYC   = 6;
    localparam int T0H_CYC   = 2;
    localparam int T1H_CYC   = 4;
    localparam int RESET_CYC = 10;
    localparam int PIX_CYC   = 24 * BIT_CYC;
    localparam int MAXC      = 16384;

    typedef struct {
        logic [23:0] c0;
        logic [23:0] c1;
        logic [23:0] grb0;
        logic [23:0] grb1;
        int          gap;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pixel_color = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [0:0]  led_idx;
    logic        led_dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    ws2812_tx #(
        .N_LEDS    (N_LEDS),
        .BIT_CYC   (BIT_CYC),
        .T0H_CYC   (T0H_CYC),
        .T1H_CYC   (T1H_CYC),
        .RESET_CYC (RESET_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .led_idx     (led_idx),
        .led_dout    (led_dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_fd = 0;
    int   n_ur = 0;
    bit   rec_on = 1'b0;
    logic rec_q[$];

    // Reference model: expected line level per cycle plus event times derived from accept cycles.
    bit exp_line [MAXC];
    int ready_from, idle_from, idx_before, idx_after, idx_switch, frame_pos, end_kind;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    task automatic model_reset(input int r);
        ready_from = r + RESET_CYC;
        idle_from  = r + RESET_CYC;
        end_kind   = 0;
        frame_pos  = 0;
        idx_before = 0;
        idx_after  = 0;
        idx_switch = 1 << 30;
        for (int i = 0; i < MAXC; i++) if (i >= r) exp_line[i] = 1'b0;
    endtask

    task automatic model_accept(input int a, input logic [23:0] color);
        int c, rr, gg, bb, grb, th, t;
        c   = int'(color);
        rr  = (c >> 16) & 255;
        gg  = (c >> 8) & 255;
        bb  = c & 255;
        grb = gg * 65536 + rr * 256 + bb;
        for (int i = 0; i < 24; i++) begin
            th = (((grb >> (23 - i)) & 1) != 0) ? T1H_CYC : T0H_CYC;
            for (int k = 0; k < BIT_CYC; k++) begin
                t = a + 1 + i * BIT_CYC + k;
                if (t < MAXC) exp_line[t] = (k < th);
            end
        end
        idx_before = frame_pos;
        idx_switch = a + PIX_CYC + 1;
        idle_from  = a + PIX_CYC + RESET_CYC + 1;
        if (frame_pos == N_LEDS - 1) begin
            idx_after  = frame_pos;
            ready_from = a + PIX_CYC + RESET_CYC + 1;
            end_kind   = 1;
            frame_pos  = 0;
        end else begin
            idx_after  = frame_pos + 1;
            ready_from = a + PIX_CYC;
            end_kind   = 2;
            frame_pos  = frame_pos + 1;
        end
    endtask

    task automatic check_cycle();
        int exp_idx;
        if (cyc >= idle_from)       exp_idx = 0;
        else if (cyc >= idx_switch) exp_idx = idx_after;
        else                        exp_idx = idx_before;
        check("led_dout", 32'(led_dout), (cyc < MAXC) ? 32'(exp_line[cyc]) : 32'd0);
        check("pixel_ready", 32'(pixel_ready), 32'(cyc >= ready_from));
        check("busy", 32'(busy), 32'(cyc < idle_from));
        check("frame_done", 32'(frame_done), 32'(cyc == idle_from && end_kind == 1));
        check("underrun", 32'(underrun), 32'(cyc == idle_from && end_kind == 2));
        check("led_idx", 32'(led_idx), 32'(exp_idx));
        if (cyc == idle_from) frame_pos = 0;
    endtask

    // Inputs are already set for the coming edge; advance to the next negedge and check.
    task automatic step(output bit acc);
        acc = chk_en && (pixel_valid === 1'b1) && (cyc >= ready_from);
        if (acc) model_accept(cyc, pixel_color);
        @(negedge clk);
        cyc++;
        if (rec_on) rec_q.push_back(led_dout);
        if (frame_done === 1'b1) n_fd++;
        if (underrun === 1'b1) n_ur++;
        if (chk_en) check_cycle();
    endtask

    task automatic send_pixel(input logic [23:0] color, input bit hold);
        bit acc;
        int n;
        pixel_color = color;
        pixel_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 400) begin
            step(acc);
            n++;
        end
        check("accept_within_bound", 32'(acc), 32'd1);
        if (!hold) pixel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit acc;
        while (cyc < idle_from + 2) step(acc);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset(cyc + 1);
        chk_en = 1'b1;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_dout"}, 32'(led_dout), 32'd0);
        check({tag, "_ready"}, 32'(pixel_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
        check({tag, "_ur"}, 32'(underrun), 32'd0);
        check({tag, "_idx"}, 32'(led_idx), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t  vec[4];
        bit          acc;
        int          fd0, ur0, nb, run, bad, w;
        logic [47:0] word;

        vec[0] = '{24'hFF0000, 24'h000000, 24'h00FF00, 24'h000000, 0};
        vec[1] = '{24'h00FF00, 24'h0000FF, 24'hFF0000, 24'h0000FF, 0};
        vec[2] = '{24'h123456, 24'hABCDEF, 24'h341256, 24'hCDABEF, 5};
        vec[3] = '{24'h800001, 24'h7FFFFE, 24'h008001, 24'hFF7FFE, 3};

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_in_reset("reset");

        fd0 = n_fd;
        release_reset();
        wait_idle();
        check("post_reset_no_fd", 32'(n_fd - fd0), 32'd0);

        for (int v = 0; v < 4; v++) begin
            fd0 = n_fd;
            ur0 = n_ur;
            rec_q.delete();
            rec_on = 1'b1;
            send_pixel(vec[v].c0, vec[v].gap == 0);
            if (vec[v].gap > 0) begin
                while (cyc < ready_from) step(acc);
                repeat (vec[v].gap) step(acc);
            end
            send_pixel(vec[v].c1, 1'b0);
            wait_idle();
            rec_on = 1'b0;

            word = '0;
            nb = 0;
            run = 0;
            bad = 0;
            foreach (rec_q[i]) begin
                if (rec_q[i] === 1'b1) run++;
                else begin
                    if (run > 0) begin
                        if (run != T0H_CYC && run != T1H_CYC) bad++;
                        word = {word[46:0], (run == T1H_CYC)};
                        nb++;
                    end
                    run = 0;
                end
            end
            check("vec_cells", 32'(nb), 32'd48);
            check("vec_bad_pulses", 32'(bad), 32'd0);
            check("vec_pix0_grb", 32'(word[47:24]), 32'(vec[v].grb0));
            check("vec_pix1_grb", 32'(word[23:0]), 32'(vec[v].grb1));
            check("vec_fd_pulses", 32'(n_fd - fd0), 32'd1);
            check("vec_ur_pulses", 32'(n_ur - ur0), 32'd0);
        end

        fd0 = n_fd;
        ur0 = n_ur;
        send_pixel(24'h00AA55, 1'b0);
        wait_idle();
        check("underrun_pulses", 32'(n_ur - ur0), 32'd1);
        check("underrun_no_fd", 32'(n_fd - fd0), 32'd0);

        for (int p = 0; p < 25; p++) begin
            w = $urandom_range(0, 14);
            while (cyc < ready_from) step(acc);
            repeat (w) step(acc);
            send_pixel(24'($urandom), 1'b0);
        end
        wait_idle();

        fd0 = n_fd;
        send_pixel(24'hFFFFFF, 1'b0);
        check("pre_reset_high", 32'(led_dout), 32'd1);
        #1 reset = 1'b0;
        chk_en = 1'b0;
        #1;
        check_in_reset("midbit_reset");
        step(acc);
        step(acc);
        release_reset();
        wait_idle();
        check("midbit_no_fd", 32'(n_fd - fd0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
